// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the 4-bit operation codes seen on the op bus and the FSM state encoding.
// Codes not listed in op_e are undefined and treated as no-ops by mdu_pipe.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the issuing pipeline and mdu_pipe.
// master (pipeline) drives start/op/a/b/flush; slave (mdu_pipe) drives busy/rdata/hi/lo.
// The pipeline must hold off issuing while busy is high; starts seen while busy are dropped.
interface mdu_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, rdata, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, rdata, hi, lo
  );

endinterface

// File: rtl/mdu_divcore.sv
// mdu_divcore: combinational signed/unsigned quotient and remainder.
// Ports: a (dividend), b (divisor), is_signed -> quo, rem. Latency 0, no flow control.
// b=0 gives quo=all ones, rem=a; signed MIN/-1 gives quo=a, rem=0; rem takes the sign of a.
module mdu_divcore #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // Divide magnitudes, then restore signs. MOST_NEG's magnitude fits as unsigned.
  assign a_neg   = is_signed & a[WIDTH-1];
  assign b_neg   = is_signed & b[WIDTH-1];
  assign abs_a   = a_neg ? (~a + 1'b1) : a;
  assign abs_b   = b_neg ? (~b + 1'b1) : b;
  // Keep the divider free of a zero divisor; that case is overridden below.
  assign divisor = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign uq      = abs_a / divisor;
  assign ur      = abs_a % divisor;

  always_comb begin
    quo = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    rem = a_neg ? (~ur + 1'b1) : ur;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else if (is_signed && (a == MOST_NEG) && (b == '1)) begin
      quo = a;
      rem = '0;
    end
  end

endmodule

// File: rtl/mdu_pipe.sv
// mdu_pipe: MIPS-style HI/LO multiply/divide unit with fixed-latency busy window.
// Ports: clk, reset (sync, active low), bus (mdu_if.slave: start/op/a/b/flush in, busy/rdata/hi/lo out).
// Latency MULT_LAT / DIV_LAT cycles of busy; MTHI/MTLO one edge; starts while busy are ignored.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built only with macro MDU_MADD_EN defined.
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_LAT);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT);

  state_e               state;
  logic [4:0]           cnt;
  logic                 busy;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  logic                 mul_signed;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;

  always_comb begin
    mul_signed = 1'b0;
    case (bus.op)
      OP_MULT: mul_signed = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: mul_signed = 1'b1;
`endif
      default: mul_signed = 1'b0;
    endcase
  end

  // One 2W x 2W multiplier: sign- or zero-extending first makes the low 2W bits
  // correct for both signed and unsigned operands.
  assign ext_a   = mul_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign ext_b   = mul_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign product = ext_a * ext_b;

  mdu_divcore #(.WIDTH(WIDTH)) u_divcore (
    .a         (bus.a),
    .b         (bus.b),
    .is_signed (bus.op == OP_DIV),
    .quo       (quo),
    .rem       (rem)
  );

`ifdef MDU_MADD_EN
  // HI/LO cannot change while an op is in flight, so accumulating against the
  // current registers at issue time is equivalent to accumulating at commit.
  logic [2*WIDTH-1:0] acc_add;
  logic [2*WIDTH-1:0] acc_sub;
  assign acc_add = {hi, lo} + product;
  assign acc_sub = {hi, lo} - product;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // flush outranks a same-cycle start.
          if (bus.start && !bus.flush) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                {res_hi, res_lo} <= product;
                cnt              <= MULT_CNT;
                busy             <= 1'b1;
                state            <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                res_lo <= quo;
                res_hi <= rem;
                cnt    <= DIV_CNT;
                busy   <= 1'b1;
                state  <= ST_RUN;
              end
              OP_MTHI: hi <= bus.a;
              OP_MTLO: lo <= bus.a;
`ifdef MDU_MADD_EN
              OP_MADD, OP_MADDU: begin
                {res_hi, res_lo} <= acc_add;
                cnt              <= MULT_CNT;
                busy             <= 1'b1;
                state            <= ST_RUN;
              end
              OP_MSUB, OP_MSUBU: begin
                {res_hi, res_lo} <= acc_sub;
                cnt              <= MULT_CNT;
                busy             <= 1'b1;
                state            <= ST_RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == 5'd1) begin
            hi    <= res_hi;
            lo    <= res_lo;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.rdata = (bus.op == OP_MFHI) ? hi :
                     (bus.op == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: directed self-checking bench for mdu_pipe with default latencies.
// Drives mdu_if one cycle at a time, 1 time unit after each rising edge, and checks
// busy window length, HI/LO and rdata against hand-computed values.
module tb_mdu_pipe;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   compared = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_pipe #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, optionally inject a start (inj_at) or a flush (flush_at) on the
  // given busy cycle, then check busy length and the final HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at, input logic [3:0] inj_op,
                        input int flush_at, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      if (n == inj_at) begin
        bus.start = 1'b1;
        bus.op    = inj_op;
        bus.a     = 32'hDEAD;
      end
      if (n == flush_at) bus.flush = 1'b1;
      step();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = OP_NOP;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_lat));
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  // Single-cycle op (MTHI/MTLO/no-op): busy must never rise.
  task automatic one_shot(input string tag, input logic [3:0] op, input logic [31:0] a);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    step();
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    check({tag, " busy"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    // Reset state
    step();
    step();
    bus.op = OP_MFHI;
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset lo", 64'(bus.lo), 64'(0));
    check("reset rdata", 64'(bus.rdata), 64'(0));
    bus.op = OP_NOP;
    reset = 1'b1;
    step();

    // Multiply, signed and unsigned
    run_op("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 0, OP_NOP, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    bus.op = OP_MFHI; #1;
    check("rdata mfhi", 64'(bus.rdata), 64'(32'hFFFFFFFF));
    bus.op = OP_MFLO; #1;
    check("rdata mflo", 64'(bus.rdata), 64'(32'hFFFFFFEB));
    bus.op = OP_MULT; #1;
    check("rdata other", 64'(bus.rdata), 64'(0));
    bus.op = OP_NOP;
    run_op("multu ffffffff*2", OP_MULTU, 32'hFFFFFFFF, 32'd2, 0, OP_NOP, 0, 5, 32'h1, 32'hFFFFFFFE);

    // Divide
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 0, OP_NOP, 0, 10, 32'd2, 32'd14);
    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, OP_NOP, 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 0, OP_NOP, 0, 10, 32'd1, 32'hFFFFFFFD);
    run_op("divu fffffff9/2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 0, OP_NOP, 0, 10, 32'd1, 32'h7FFFFFFC);
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 0, OP_NOP, 0, 10, 32'd5, 32'hFFFFFFFF);
    run_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, OP_NOP, 0, 10, 32'd0, 32'h80000000);

    // Moves into HI/LO
    one_shot("mthi", OP_MTHI, 32'h1234);
    check("mthi hi", 64'(bus.hi), 64'(32'h1234));
    one_shot("mtlo", OP_MTLO, 32'h5678);
    check("mtlo lo", 64'(bus.lo), 64'(32'h5678));

    // MTLO while busy is ignored
    run_op("mult 6*7 +mtlo", OP_MULT, 32'd6, 32'd7, 2, OP_MTLO, 0, 5, 32'd0, 32'd42);

    // Flush mid-divide keeps HI/LO, then a new multiply is accepted
    run_op("div flush", OP_DIV, 32'd9, 32'd2, 0, OP_NOP, 4, 4, 32'd0, 32'd42);
    run_op("mult after flush", OP_MULT, 32'd2, 32'd3, 0, OP_NOP, 0, 5, 32'd0, 32'd6);

    // flush beats start in IDLE
    bus.flush = 1'b1;
    one_shot("flush+start", OP_MULT, 32'd5);
    bus.flush = 1'b0;
    step();
    check("flush+start busy later", 64'(bus.busy), 64'(0));
    check("flush+start lo", 64'(bus.lo), 64'(6));

    // Undefined op code is a no-op
    one_shot("undef op", 4'hF, 32'hBEEF);
    check("undef hi", 64'(bus.hi), 64'(0));
    check("undef lo", 64'(bus.lo), 64'(6));

    // Reset in the middle of a multiply
    one_shot("mthi pre-reset", OP_MTHI, 32'hAA);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3;
    step();
    bus.start = 1'b0; bus.op = OP_NOP;
    check("mid-mult busy", 64'(bus.busy), 64'(1));
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("reset mid busy", 64'(bus.busy), 64'(0));
    check("reset mid hi", 64'(bus.hi), 64'(0));
    check("reset mid lo", 64'(bus.lo), 64'(0));
    step();
    check("reset mid busy after", 64'(bus.busy), 64'(0));

    // Accumulate ops
    one_shot("mtlo 10", OP_MTLO, 32'd10);
    check("pre-madd lo", 64'(bus.lo), 64'(10));
`ifdef MDU_MADD_EN
    run_op("madd 3*4", OP_MADD, 32'd3, 32'd4, 0, OP_NOP, 0, 5, 32'd0, 32'd22);
    run_op("msubu 1*2", OP_MSUBU, 32'd1, 32'd2, 0, OP_NOP, 0, 5, 32'd0, 32'd20);
`else
    one_shot("madd disabled", OP_MADD, 32'd3);
    step();
    check("madd disabled busy", 64'(bus.busy), 64'(0));
    check("madd disabled hi", 64'(bus.hi), 64'(0));
    check("madd disabled lo", 64'(bus.lo), 64'(10));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
MDU_PIPE -- requirements
Module: mdu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width in bits.
REQ-002 Parameter MULT_LAT, default 5: multiply busy cycles, range 1..31.
REQ-003 Parameter DIV_LAT, default 10: divide busy cycles, range 1..31.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: issue the op on op in the current cycle.
REQ-007 Port op, input, 4: operation code from mdu_pkg.
REQ-008 Port a, input, WIDTH: rs operand.
REQ-009 Port b, input, WIDTH: rt operand.
REQ-010 Port flush, input, 1: abort the in-flight multiply or divide.
REQ-011 Port busy, output, 1: a multiply or divide is in flight.
REQ-012 Port rdata, output, WIDTH: combinational HI when op=MFHI, LO when op=MFLO, else 0.
REQ-013 Ports hi and lo, output, WIDTH each: architectural register contents.

Function
REQ-014 SHALL implement states IDLE and RUN, with a 5-bit down-counter cnt.
REQ-015 In IDLE, start with MULT/MULTU SHALL latch the full product, load cnt=MULT_LAT and enter RUN.
REQ-016 In IDLE, start with DIV/DIVU SHALL latch quotient and remainder, load cnt=DIV_LAT and enter RUN.
REQ-017 busy SHALL be high in the cycle after an accepted start and remain high for exactly LAT cycles.
REQ-018 In RUN, cnt SHALL decrement each cycle; at cnt=1 the next edge SHALL commit HI/LO and return to IDLE.
REQ-019 HI/LO SHALL commit as follows: multiply gives HI=product[2W-1:W], LO=product[W-1:0]; divide gives LO=quotient, HI=remainder.
REQ-020 MULT and DIV SHALL be signed; MULTU and DIVU SHALL be unsigned; the remainder SHALL take the sign of the dividend.
REQ-021 Division by zero SHALL give LO=all ones and HI=a, with normal latency.
REQ-022 Signed overflow (most-negative value / -1) SHALL give LO=a and HI=0.
REQ-023 MTHI/MTLO with start in IDLE SHALL write a to HI/LO at the next edge; busy SHALL stay low.
REQ-024 Any start while busy SHALL be ignored with no state change; the issuing pipeline stalls on busy.
REQ-025 flush in RUN SHALL return to IDLE at the next edge with HI/LO unchanged.
REQ-026 If flush and start occur in the same cycle in IDLE, flush SHALL take priority and start SHALL be dropped.
REQ-027 A commit and a new start SHALL never coincide: start is accepted only in IDLE.
REQ-028 Undefined op codes with start SHALL be treated as no-ops.

Reset
REQ-029 While reset=0 at an edge: state=IDLE, cnt=0, HI=0, LO=0, busy=0, latched results cleared.
REQ-030 Reset during RUN SHALL discard the operation; HI/LO SHALL read 0 afterwards.

Configuration
REQ-031 With macro MDU_MADD_EN defined, SHALL add MADD, MADDU, MSUB and MSUBU: {HI,LO} +/- product, using MULT_LAT and the same signedness rules.
REQ-032 Without MDU_MADD_EN, those op codes SHALL behave as undefined no-ops, and no accumulate adder SHALL be synthesised.

Structure
REQ-033 Package mdu_pkg SHALL hold the op code constants and the state encoding.
REQ-034 Signed and unsigned quotient/remainder generation, including the zero and overflow cases, SHALL be a sub-module named mdu_divcore.
REQ-035 The multiply product SHALL stay inline in mdu_pipe.

Verification
REQ-036 Directed test: MULT a=-3, b=7 -> busy high for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-037 Directed test: DIVU a=100, b=7 -> busy for 10 cycles, LO=14, HI=2; DIV a=-7, b=2 -> LO=-3, HI=-1.
REQ-038 Directed test: DIV a=5, b=0 -> LO=32'hFFFFFFFF, HI=5; DIV a=32'h80000000, b=-1 -> LO=32'h80000000, HI=0.
REQ-039 Directed test: MULT issued, then MTLO issued on busy cycle 2 -> MTLO ignored; final LO equals the product.
REQ-040 Directed test: DIV issued, flush on busy cycle 4 -> busy low next cycle, HI/LO keep prior values, a new MULT is accepted.
REQ-041 Directed test: reset=0 in mid-MULT -> busy=0, HI=LO=0; with MDU_MADD_EN, HI=0, LO=10, then MADD 3*4 -> LO=22.
